// File: rtl/spi_wr_seq.sv
// Streams a host-loaded table of 32-bit words to the SPI master over AXI-Stream. First word 1 cycle after start, then back-to-back.
// Holds tvalid/tdata under tready backpressure, then waits for wr_data_num to confirm all words (or times out).
module spi_wr_seq #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   seq_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   sent_cnt,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [15:0]       wr_data_num
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [23:0]     TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              tvalid_q, tvalid_d;
  logic [31:0]       tdata_q, tdata_d;
  logic [ADDR_W:0]   sent_q, sent_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       base_q, base_d;
  logic [23:0]       timer_q, timer_d;
  logic [31:0]       tbl_q [DEPTH];

  logic        tbl_we, hs, last_word, len_ok;
  logic [31:0] first_word;
  logic [15:0] confirmed;

  assign tbl_we     = load_we && (state_q == IDLE);
  // A write to entry 0 in the start cycle must be seen by the first word.
  assign first_word = (tbl_we && (load_addr == '0)) ? load_data : tbl_q[0];
  assign hs         = tvalid_q && m_axis_tready;
  assign last_word  = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));
  assign len_ok     = (seq_len != '0) && (seq_len <= DEPTH_L);
  assign confirmed  = wr_data_num - base_q;

  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[load_addr] <= load_data;
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    err_d    = err_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    sent_d   = sent_q;
    len_d    = len_q;
    idx_d    = idx_q;
    base_d   = base_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d  = SEND;
            busy_d   = 1'b1;
            err_d    = 1'b0;
            len_d    = seq_len;
            base_d   = wr_data_num;
            idx_d    = '0;
            sent_d   = '0;
            tvalid_d = 1'b1;
            tdata_d  = first_word;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      SEND: begin
        if (hs) begin
          sent_d = sent_q + (ADDR_W+1)'(1);
          idx_d  = idx_q + ADDR_W'(1);
          if (last_word) begin
            tvalid_d = 1'b0;
            timer_d  = '0;
            state_d  = WAIT_TX;
          end else begin
            tdata_d = tbl_q[idx_q + ADDR_W'(1)];
          end
        end
      end
      WAIT_TX: begin
        if (confirmed == 16'(len_q)) begin
          state_d = DONE;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      sent_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      sent_q   <= sent_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      timer_q  <= timer_d;
    end
  end

  assign busy          = busy_q;
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign sent_cnt      = sent_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
endmodule

// File: tb/tb_spi_wr_seq.sv
// Bench for spi_wr_seq: a negedge environment models the SPI master (tready patterns, delayed wr_data_num)
// and collects the stream; the main process checks words, counts, done timing and err against a table model.
module tb_spi_wr_seq;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_we = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [31:0]       load_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   seq_len = '0;
  logic              busy, done, err, tvalid;
  logic [ADDR_W:0]   sent_cnt;
  logic [31:0]       tdata;
  logic              tready = 1'b1;
  logic [15:0]       wdn = '0;

  spi_wr_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .seq_len(seq_len), .busy(busy), .done(done), .err(err), .sent_cnt(sent_cnt),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .wr_data_num(wdn)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] mdl [DEPTH];
  logic [31:0] rxq [$];
  int          pend [$];
  int          cyc = 0;
  int          mode = 0;
  bit          freeze = 1'b0;
  logic [15:0] tgt = '0;
  int          done_cnt = 0, done_cyc = -1, hit_cyc = -1, last_hs = -1, tv_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;

  // Master model: word counter advances 4 cycles after each accepted word.
  initial forever begin
    @(negedge clk);
    cyc++;
    case (mode)
      0:       tready = 1'b1;
      1:       tready = ((cyc / 3) % 2) == 0;
      default: tready = 1'($urandom_range(0, 1));
    endcase
    for (int i = 0; i < pend.size(); i++) pend[i] = pend[i] - 1;
    while (pend.size() > 0 && pend[0] <= 0) begin
      void'(pend.pop_front());
      if (!freeze) begin
        wdn = wdn + 16'd1;
        if (wdn == tgt && hit_cyc < 0) hit_cyc = cyc;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tvalid) tv_cnt++;
    if (prev_stall && rst_n) begin
      check("hold_vld", 32'(tvalid), 32'd1);
      check("hold_dat", tdata, prev_dat);
    end
    prev_stall = rst_n && tvalid && !tready;
    prev_dat   = tdata;
    if (rst_n && tvalid && tready) begin
      rxq.push_back(tdata);
      pend.push_back(4);
      last_hs = cyc;
    end
  end

  task automatic load(input int a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = ADDR_W'(a);
    load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic run_seq(input int len, input int md, input bit frz, input logic [15:0] b,
                         input bit wr_same, input bit poke_busy);
    rxq.delete();
    pend.delete();
    done_cnt = 0; hit_cyc = -1; last_hs = -1;
    mode = md; freeze = frz; wdn = b; tgt = b + 16'(len);
    @(posedge clk); #1;
    start   = 1'b1;
    seq_len = (ADDR_W+1)'(len);
    if (wr_same) begin
      load_we = 1'b1; load_addr = '0; load_data = $urandom;
      mdl[0] = load_data;
    end
    @(posedge clk); #1;
    start = 1'b0; load_we = 1'b0;
    check("busy_on", 32'(busy), 32'd1);
    if (poke_busy) begin
      load_we = 1'b1; load_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); load_data = $urandom;
      @(posedge clk); #1;
      load_we = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 32'(done_cnt), 32'd1);
    check("word_count", 32'(rxq.size()), 32'(len));
    for (int i = 0; i < len && i < rxq.size(); i++) check($sformatf("word%0d", i), rxq[i], mdl[i]);
    check("sent_cnt", 32'(sent_cnt), 32'(len));
    check("busy_off", 32'(busy), 32'd0);
    if (frz) begin
      check("tmo_time", 32'(done_cyc), 32'(last_hs + TMO + 1));
      check("tmo_err", 32'(err), 32'd1);
    end else begin
      check("done_time", 32'(done_cyc), 32'(hit_cyc + 1));
      check("err_clr", 32'(err), 32'd0);
    end
  endtask

  task automatic bad_start(input int len);
    done_cnt = 0; tv_cnt = 0; mode = 0;
    @(posedge clk); #1;
    start = 1'b1; seq_len = (ADDR_W+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("bad%0d_done", len), 32'(done_cnt), 32'd1);
    check($sformatf("bad%0d_err", len), 32'(err), 32'd1);
    check($sformatf("bad%0d_novld", len), 32'(tv_cnt), 32'd0);
  endtask

  task automatic reset_mid();
    rxq.delete(); pend.delete();
    mode = 0; freeze = 1'b0; wdn = '0; tgt = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b1; seq_len = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && rxq.size() < 2; i++) @(posedge clk);
    #3;
    check("rm_pre_vld", 32'(tvalid), 32'd1);
    check("rm_pre_cnt", 32'(sent_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rm_vld", 32'(tvalid), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_cnt", 32'(sent_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pend.delete();
    prev_stall = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(sent_cnt), 32'd0);
    check("rst_vld", 32'(tvalid), 32'd0);
    check("rst_dat", tdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    load(0, 32'hA5A5_0001);
    load(1, 32'h0000_BEEF);
    load(2, 32'h1234_5678);

    run_seq(3, 0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_seq(3, 1, 1'b0, 16'h0200, 1'b0, 1'b0);
    bad_start(0);
    bad_start(DEPTH + 1);
    run_seq(DEPTH, 2, 1'b0, 16'h1234, 1'b1, 1'b1);
    run_seq(4, 0, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    check("wrap_wdn", 32'(wdn), 32'h0002);
    run_seq(3, 0, 1'b1, 16'h0050, 1'b0, 1'b0);
    reset_mid();
    run_seq(DEPTH, 1, 1'b0, 16'h7000, 1'b0, 1'b1);

    for (int it = 0; it < 6; it++) begin
      load($urandom_range(0, DEPTH - 1), $urandom);
      run_seq($urandom_range(1, DEPTH), $urandom_range(0, 2), 1'b0, 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_wr_seq.md
Name: spi_wr_seq

Overview:
- Upstream command sequencer for the SPI master.
- Holds a table of up to DEPTH 32-bit write words, loaded by a host/config port.
- On start, streams table entries 0..seq_len-1 over AXI-Stream into the SPI master's s_axis input.
- Uses the master's wr_data_num counter to confirm every word actually left the wire, then reports done or error.

Parameters:
- DEPTH, 16, number of table entries (power of two, 2..256).
- ADDR_W, 4, table address width; equals log2(DEPTH).
- TIMEOUT_CYCLES, 1_000_000, clk cycles allowed in WAIT_TX before error (must be < 2^24).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- load_we  input  1  table write strobe.
- load_addr  input  ADDR_W  table write address.
- load_data  input  32  table write data.
- start  input  1  single-cycle sequence start request.
- seq_len  input  ADDR_W+1  number of words to send; sampled on accepted start.
- busy  output  1  high from accepted start until DONE exits.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky error flag for the last sequence.
- sent_cnt  output  ADDR_W+1  words handed to the master so far in the current sequence.
- m_axis_tdata  output  32  word to the SPI master (to s_axis_tdata).
- m_axis_tvalid  output  1  data valid (to s_axis_tvalid).
- m_axis_tready  input  1  from the SPI master's s_axis_tready.
- wr_data_num  input  16  from the SPI master: total words sent in write-only mode.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, err=0, sent_cnt=0, m_axis_tvalid=0, m_axis_tdata=0, idx=0, base=0, timer=0.
- Table contents are not reset.
- Table writes:
  - load_we takes effect on the clock edge only in IDLE.
  - Writes are ignored while busy=1.
  - A write and a start in the same IDLE cycle: the write lands first, and the sequence sees the new value.
- State IDLE:
  - start=1 with 1<=seq_len<=DEPTH: latch len, latch base=wr_data_num, idx=0, sent_cnt=0, err=0, busy=1, go to SEND.
  - start=1 with seq_len=0 or seq_len>DEPTH: go to DONE with err=1; no stream traffic.
- State SEND:
  - m_axis_tvalid=1 and m_axis_tdata=table[idx], both registered; tvalid is first high the cycle after start is accepted.
  - AXIS rules: once tvalid is high, tvalid and tdata hold until tvalid&&tready; no combinational path from tready to tvalid.
  - On handshake: sent_cnt++, idx++.
  - If the handshaken word is entry len-1: tvalid=0 next cycle, timer=0, go to WAIT_TX.
  - Otherwise the next word is presented the following cycle (one bubble allowed).
- State WAIT_TX:
  - Each cycle compute (wr_data_num - base) mod 2^16, unsigned 16-bit subtraction, so wrap of wr_data_num is correct.
  - When the result equals len: go to DONE with err unchanged.
  - Otherwise timer++; when timer reaches TIMEOUT_CYCLES-1: err=1, go to DONE.
- State DONE: done=1 for exactly one cycle, busy=0 on exit, return to IDLE. err holds until the next accepted start.
- start while busy is ignored, with no queuing.
- Reset mid-SEND drops tvalid immediately (async); the downstream master must be reset by the same rst_n.
- Throughput is limited by the master's tready; the sequencer adds at most 1 idle cycle between words.

Test Plan:
- Load table[0..2]=0xA5A5_0001/0x0000_BEEF/0x1234_5678, start with seq_len=3, tready always 1, wr_data_num incrementing 4 cycles after each handshake -> tdata shows the three words in order, sent_cnt=3, done pulses once after wr_data_num=base+3, err=0.
- Same sequence with tready toggling 0/1 every 3 cycles -> tvalid/tdata stable through every tready=0 stall, no word dropped or duplicated.
- Start with seq_len=0 and again with seq_len=DEPTH+1 -> no tvalid, done pulse within 2 cycles, err=1. A following valid start clears err.
- Base wr_data_num=0xFFFE, seq_len=4 -> done when wr_data_num=0x0002 (wrap handled).
- wr_data_num frozen after handshakes, TIMEOUT_CYCLES=100 -> done and err=1 exactly 100 cycles after entering WAIT_TX.
- Assert rst_n=0 mid-SEND at idx=2 -> tvalid, busy, sent_cnt go to 0 asynchronously. load_we during busy leaves the table unchanged (readback in the next sequence).
